two_bit_compare_slice: RTL and testbench



---
 rtl/two_bit_compare_slice.sv | 52 +++++
 tb/tb_two_bit_compare_slice.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/two_bit_compare_slice.sv
`default_nettype none
// ============================================================================
// Module      : two_bit_compare_slice
// Description : Registered 2-bit unsigned magnitude-compare slice. Combines the
//               local compare of A/B with the cascade status (lt/eq) from the
//               next-more-significant slice and registers the combined LT/EQ
//               for the next-less-significant slice (or as the final result).
//               "Greater than" is LT=0, EQ=0.
// Revision    : 1.0 - initial release
// ============================================================================
module two_bit_compare_slice (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       lt,
  input  logic       eq,
  output logic       EQ,
  output logic       LT
);

  // Reset values equal the cascade identity (lt=0, eq=1), so a slice held in
  // reset looks like "equal so far" to whatever it feeds.
  localparam logic c_lt_reset = 1'b0;
  localparam logic c_eq_reset = 1'b1;

  logic a_eq;
  logic a_lt;
  logic lt_next;
  logic eq_next;

  // Local compare and cascade merge; lt dominates, so lt=1,eq=1 reads as less-than
  always_comb begin
    a_eq    = (A == B);
    a_lt    = (A < B);
    lt_next = lt | (eq & ~lt & a_lt);
    eq_next = eq & ~lt & a_eq;
  end

  // Output register with asynchronous active-low reset to the cascade identity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LT <= c_lt_reset;
      EQ <= c_eq_reset;
    end else begin
      LT <= lt_next;
      EQ <= eq_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_two_bit_compare_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_two_bit_compare_slice
// Description : Self-checking bench for two_bit_compare_slice. A behavioural
//               model predicts LT/EQ from the inputs captured at each rising
//               edge; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_two_bit_compare_slice;

  logic       clk;
  logic       rst_n;
  logic [1:0] A;
  logic [1:0] B;
  logic       lt;
  logic       eq;
  logic       EQ;
  logic       LT;

  int errors = 0;
  int checks = 0;

  two_bit_compare_slice dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .lt    (lt),
    .eq    (eq),
    .EQ    (EQ),
    .LT    (LT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: result {LT, EQ} from the comparison rules
  function automatic logic [1:0] model(input int a, input int b, input bit l, input bit e);
    if (l)     return 2'b10;   // upstream already less-than (dominates)
    if (!e)    return 2'b00;   // upstream already greater-than
    if (a < b) return 2'b10;
    if (a == b) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got LT,EQ=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every rising edge the model predicts the registered result
  initial begin
    logic [1:0] exp;
    forever begin
      @(posedge clk);
      if (!rst_n) exp = 2'b01;
      else        exp = model(int'(A), int'(B), lt, eq);
      #2;
      if (rst_n) begin
        check("model", {LT, EQ}, exp);
        checks++;
        if (LT && EQ) begin
          errors++;
          $display("FAIL both_set: got LT,EQ=%b required not 11", {LT, EQ});
        end
      end
    end
  end

  // Drive one input vector on the falling edge; return once it has been captured
  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic l, input logic e);
    @(negedge clk);
    A = a; B = b; lt = l; eq = e;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1;
    A = 2'd3; B = 2'd0; lt = 1'b1; eq = 1'b0;

    // Asynchronous reset takes effect before any clock edge
    #1 rst_n = 1'b0;
    #1 check("reset_immediate", {LT, EQ}, 2'b01);
    repeat (2) @(posedge clk);
    #2 check("reset_hold", {LT, EQ}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 check("reset_release", {LT, EQ}, 2'b10);

    // Equal and MSB toggles
    step(2'd3, 2'd3, 1'b0, 1'b1); check("eq_33", {LT, EQ}, 2'b01);
    step(2'd1, 2'd3, 1'b0, 1'b1); check("lt_13", {LT, EQ}, 2'b10);
    step(2'd3, 2'd3, 1'b0, 1'b1); check("eq_33b", {LT, EQ}, 2'b01);
    step(2'd2, 2'd3, 1'b0, 1'b1); check("lt_23", {LT, EQ}, 2'b10);
    step(2'd3, 2'd3, 1'b0, 1'b1); check("eq_33c", {LT, EQ}, 2'b01);

    // Zero and B toggles
    step(2'd0, 2'd0, 1'b0, 1'b1); check("eq_00", {LT, EQ}, 2'b01);
    step(2'd0, 2'd2, 1'b0, 1'b1); check("lt_02", {LT, EQ}, 2'b10);
    step(2'd0, 2'd0, 1'b0, 1'b1); check("eq_00b", {LT, EQ}, 2'b01);
    step(2'd0, 2'd1, 1'b0, 1'b1); check("lt_01", {LT, EQ}, 2'b10);
    step(2'd0, 2'd0, 1'b0, 1'b1); check("eq_00c", {LT, EQ}, 2'b01);

    // Greater-than
    step(2'd2, 2'd1, 1'b0, 1'b1); check("gt_21", {LT, EQ}, 2'b00);
    step(2'd3, 2'd0, 1'b0, 1'b1); check("gt_30", {LT, EQ}, 2'b00);

    // Cascade override
    step(2'd3, 2'd0, 1'b1, 1'b0); check("casc_lt", {LT, EQ}, 2'b10);
    step(2'd0, 2'd3, 1'b0, 1'b0); check("casc_gt", {LT, EQ}, 2'b00);
    step(2'd2, 2'd2, 1'b1, 1'b1); check("casc_illegal", {LT, EQ}, 2'b10);

    // Reset mid-operation discards the pending result
    step(2'd1, 2'd3, 1'b0, 1'b1); check("pre_midreset", {LT, EQ}, 2'b10);
    @(negedge clk);
    A = 2'd2; B = 2'd0; lt = 1'b0; eq = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("midreset_immediate", {LT, EQ}, 2'b01);
    @(posedge clk);
    #2 check("midreset_hold", {LT, EQ}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 check("midreset_release", {LT, EQ}, 2'b00);

    // Exhaustive sweep, checked by the compare process
    for (int i = 0; i < 64; i++) begin
      step(i[1:0], i[3:2], i[4], i[5]);
    end

    // Randomized stimulus
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(3)), 2'($urandom_range(3)),
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
